// File: rtl/ycbcr_pkg.sv
// ----------------------------------------------------------------------------
// ycbcr_pkg
// Shared definitions for the multi-standard RGB-to-YCbCr converter:
//   - std_e     : colour-standard encoding (matches the std_sel port values)
//   - coef_t    : signed coefficient type, value x256
//   - COEF_TAB  : [standard][channel Y/Cb/Cr][component R/G/B] coefficients
//   - Y_OFS_STUDIO_8 / C_OFS_8 : luma/chroma offsets at 8-bit scale
//   - is_studio : true for the studio-swing standards (luma offset applied)
// ----------------------------------------------------------------------------
package ycbcr_pkg;

    typedef enum logic [1:0] {
        STD_601_FULL   = 2'd0,
        STD_601_STUDIO = 2'd1,
        STD_709_FULL   = 2'd2,
        STD_709_STUDIO = 2'd3
    } std_e;

    localparam int COEF_W = 10;
    typedef logic signed [COEF_W-1:0] coef_t;

    localparam int CH_Y  = 0;
    localparam int CH_CB = 1;
    localparam int CH_CR = 2;

    localparam coef_t COEF_TAB [4][3][3] = '{
        // BT.601 full range
        '{ '{ 10'sd77,   10'sd150,  10'sd29  },
           '{ -10'sd43,  -10'sd85,  10'sd128 },
           '{ 10'sd128,  -10'sd107, -10'sd21 } },
        // BT.601 studio range
        '{ '{ 10'sd66,   10'sd129,  10'sd25  },
           '{ -10'sd38,  -10'sd74,  10'sd112 },
           '{ 10'sd112,  -10'sd94,  -10'sd18 } },
        // BT.709 full range
        '{ '{ 10'sd54,   10'sd183,  10'sd19  },
           '{ -10'sd29,  -10'sd99,  10'sd128 },
           '{ 10'sd128,  -10'sd116, -10'sd12 } },
        // BT.709 studio range
        '{ '{ 10'sd47,   10'sd157,  10'sd16  },
           '{ -10'sd26,  -10'sd86,  10'sd112 },
           '{ 10'sd112,  -10'sd102, -10'sd10 } }
    };

    localparam logic [7:0] Y_OFS_STUDIO_8 = 8'd16;
    localparam logic [7:0] C_OFS_8        = 8'd128;

    function automatic logic is_studio(input std_e s);
        return (s == STD_601_STUDIO) || (s == STD_709_STUDIO);
    endfunction

endpackage

// File: rtl/ycbcr_lane.sv
// ----------------------------------------------------------------------------
// ycbcr_lane
// One output channel of the converter. Two register stages plus a
// combinational saturator that feeds the top-level stage-3 register:
//   stage 1 : three signed multiplies coef * component
//   stage 2 : sum + (offset << FRAC) + rounding constant
//   comb    : arithmetic shift right by FRAC, clamp to [0, 2^DW-1]
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_coef_r/g/b   coef_t      coefficients for the pixel entering stage 1
//   i_r/g/b        [DW-1:0]    input components (unsigned)
//   i_offset       [DW-1:0]    channel offset, aligned with stage-1 products
//   o_sat          [DW-1:0]    rounded, saturated result (valid after stage 2)
// ----------------------------------------------------------------------------
module ycbcr_lane
    import ycbcr_pkg::*;
#(
    parameter int DW   = 8,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  coef_t         i_coef_r,
    input  coef_t         i_coef_g,
    input  coef_t         i_coef_b,
    input  logic [DW-1:0] i_r,
    input  logic [DW-1:0] i_g,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_offset,
    output logic [DW-1:0] o_sat
);

    // Product width: signed coefficient times a zero-extended component.
    localparam int PW = DW + COEF_W + 1;
    localparam int AW = DW + 12;
    localparam logic signed [AW-1:0] ROUND   = AW'(1 << (FRAC - 1));
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << DW) - 1);

    logic signed [PW-1:0] w_kr, w_kg, w_kb;
    logic signed [PW-1:0] w_xr, w_xg, w_xb;
    logic signed [PW-1:0] r_prod_r, r_prod_g, r_prod_b;
    logic signed [AW-1:0] w_ofs, w_sum, r_acc, w_shr;

    assign w_kr = PW'(i_coef_r);
    assign w_kg = PW'(i_coef_g);
    assign w_kb = PW'(i_coef_b);
    assign w_xr = PW'({1'b0, i_r});
    assign w_xg = PW'({1'b0, i_g});
    assign w_xb = PW'({1'b0, i_b});

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours regardless of block order.
    // NOTE: the pipeline registers are reset so that nothing stale can leak
    // to the outputs after a mid-frame reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_r <= '0;
            r_prod_g <= '0;
            r_prod_b <= '0;
        end else begin
            r_prod_r <= w_kr * w_xr;
            r_prod_g <= w_kg * w_xg;
            r_prod_b <= w_kb * w_xb;
        end
    end

    assign w_ofs = AW'(i_offset) << FRAC;
    assign w_sum = AW'(r_prod_r) + AW'(r_prod_g) + AW'(r_prod_b) + w_ofs + ROUND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum;
        end
    end

    assign w_shr = r_acc >>> FRAC;

    // NOTE: o_sat gets a default before the branches so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        o_sat = '0;
        if (w_shr[AW-1]) begin
            o_sat = '0;
        end else if (w_shr > SAT_MAX) begin
            o_sat = '1;
        end else begin
            o_sat = w_shr[DW-1:0];
        end
    end

endmodule

// File: rtl/rgb2ycbcr_multistd.sv
// ----------------------------------------------------------------------------
// rgb2ycbcr_multistd
// RGB to YCbCr converter on a vsync/href pixel stream, four colour standards,
// rounded and saturated outputs, optional 4:2:2 co-sited chroma.
// Fixed 3-cycle latency for data, href and vsync; one pixel per clock.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   std_sel [1:0]                       standard, captured on vsync rise
//   fmt_422                             0 = 4:4:4, 1 = 4:2:2, captured on vsync rise
//   before_img_vsync / before_img_href  input frame / line syncs
//   before_img_red/green/blue [DW-1:0]  input components
//   after_img_vsync / after_img_href    syncs delayed 3 cycles
//   after_img_Y  [DW-1:0]               luma
//   after_img_Cb [DW-1:0]               Cb (4:4:4) or interleaved Cb/Cr (4:2:2)
//   after_img_Cr [DW-1:0]               Cr (4:4:4) or 0 (4:2:2)
// ----------------------------------------------------------------------------
module rgb2ycbcr_multistd
    import ycbcr_pkg::*;
#(
    parameter int DW   = 8,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    std_sel,
    input  logic          fmt_422,
    input  logic          before_img_vsync,
    input  logic          before_img_href,
    input  logic [DW-1:0] before_img_red,
    input  logic [DW-1:0] before_img_green,
    input  logic [DW-1:0] before_img_blue,
    output logic          after_img_vsync,
    output logic          after_img_href,
    output logic [DW-1:0] after_img_Y,
    output logic [DW-1:0] after_img_Cb,
    output logic [DW-1:0] after_img_Cr
);

    // ------------------------------------------------------------------
    // Mode capture and 4:2:2 phase (input side)
    // ------------------------------------------------------------------
    logic r_vs_prev, r_hs_prev;
    std_e r_std;
    logic r_fmt;
    logic r_phase;

    logic w_vs_rise, w_hs_rise;
    std_e w_std;
    logic w_fmt;
    logic w_phase;

    assign w_vs_rise = before_img_vsync & ~r_vs_prev;
    assign w_hs_rise = before_img_href & ~r_hs_prev;

    // On the rise cycle itself the incoming mode is already in force, so a
    // mode change presented together with the vsync edge is never lost.
    assign w_std   = w_vs_rise ? std_e'(std_sel) : r_std;
    assign w_fmt   = w_vs_rise ? fmt_422 : r_fmt;
    assign w_phase = w_hs_rise ? 1'b0 : r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev <= 1'b0;
            r_hs_prev <= 1'b0;
            r_std     <= STD_601_FULL;
            r_fmt     <= 1'b0;
            r_phase   <= 1'b0;
        end else begin
            r_vs_prev <= before_img_vsync;
            r_hs_prev <= before_img_href;
            r_std     <= w_std;
            r_fmt     <= w_fmt;
            if (before_img_href) begin
                r_phase <= ~w_phase;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sync delay lines and per-pixel mode tags
    // ------------------------------------------------------------------
    logic r_s1_vs, r_s1_hs, r_s1_fmt, r_s1_ph;
    std_e r_s1_std;
    logic r_s2_vs, r_s2_hs, r_s2_fmt, r_s2_ph;
    logic r_s3_vs, r_s3_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vs  <= 1'b0;
            r_s1_hs  <= 1'b0;
            r_s1_std <= STD_601_FULL;
            r_s1_fmt <= 1'b0;
            r_s1_ph  <= 1'b0;
            r_s2_vs  <= 1'b0;
            r_s2_hs  <= 1'b0;
            r_s2_fmt <= 1'b0;
            r_s2_ph  <= 1'b0;
            r_s3_vs  <= 1'b0;
            r_s3_hs  <= 1'b0;
        end else begin
            r_s1_vs  <= before_img_vsync;
            r_s1_hs  <= before_img_href;
            r_s1_std <= w_std;
            r_s1_fmt <= w_fmt;
            r_s1_ph  <= w_phase;
            r_s2_vs  <= r_s1_vs;
            r_s2_hs  <= r_s1_hs;
            r_s2_fmt <= r_s1_fmt;
            r_s2_ph  <= r_s1_ph;
            r_s3_vs  <= r_s2_vs;
            r_s3_hs  <= r_s2_hs;
        end
    end

    // ------------------------------------------------------------------
    // Channel lanes. Offsets enter at stage 2, so they follow the stage-1
    // standard tag rather than the live mode.
    // ------------------------------------------------------------------
    logic [DW-1:0] w_y_ofs, w_c_ofs;
    logic [DW-1:0] w_y, w_cb, w_cr;

    assign w_y_ofs = is_studio(r_s1_std) ? (DW'(Y_OFS_STUDIO_8) << (DW - 8)) : '0;
    assign w_c_ofs = DW'(C_OFS_8) << (DW - 8);

    ycbcr_lane #(.DW(DW), .FRAC(FRAC)) u_lane_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_coef_r (COEF_TAB[w_std][CH_Y][0]),
        .i_coef_g (COEF_TAB[w_std][CH_Y][1]),
        .i_coef_b (COEF_TAB[w_std][CH_Y][2]),
        .i_r      (before_img_red),
        .i_g      (before_img_green),
        .i_b      (before_img_blue),
        .i_offset (w_y_ofs),
        .o_sat    (w_y)
    );

    ycbcr_lane #(.DW(DW), .FRAC(FRAC)) u_lane_cb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_coef_r (COEF_TAB[w_std][CH_CB][0]),
        .i_coef_g (COEF_TAB[w_std][CH_CB][1]),
        .i_coef_b (COEF_TAB[w_std][CH_CB][2]),
        .i_r      (before_img_red),
        .i_g      (before_img_green),
        .i_b      (before_img_blue),
        .i_offset (w_c_ofs),
        .o_sat    (w_cb)
    );

    ycbcr_lane #(.DW(DW), .FRAC(FRAC)) u_lane_cr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_coef_r (COEF_TAB[w_std][CH_CR][0]),
        .i_coef_g (COEF_TAB[w_std][CH_CR][1]),
        .i_coef_b (COEF_TAB[w_std][CH_CR][2]),
        .i_r      (before_img_red),
        .i_g      (before_img_green),
        .i_b      (before_img_blue),
        .i_offset (w_c_ofs),
        .o_sat    (w_cr)
    );

    // ------------------------------------------------------------------
    // Stage 3: output registers and 4:2:2 interleave. The odd pixel of a
    // pair outputs the Cr held from its even partner; an unpaired last even
    // pixel simply never gets its Cr emitted.
    // ------------------------------------------------------------------
    logic [DW-1:0] r_y, r_cb, r_cr, r_cr_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_cb      <= '0;
            r_cr      <= '0;
            r_cr_hold <= '0;
        end else if (r_s2_hs) begin
            r_y <= w_y;
            if (r_s2_fmt) begin
                r_cr <= '0;
                if (!r_s2_ph) begin
                    r_cb      <= w_cb;
                    r_cr_hold <= w_cr;
                end else begin
                    r_cb <= r_cr_hold;
                end
            end else begin
                r_cb <= w_cb;
                r_cr <= w_cr;
            end
        end else begin
            r_y  <= '0;
            r_cb <= '0;
            r_cr <= '0;
        end
    end

    assign after_img_vsync = r_s3_vs;
    assign after_img_href  = r_s3_hs;
    assign after_img_Y     = r_y;
    assign after_img_Cb    = r_cb;
    assign after_img_Cr    = r_cr;

endmodule
